// File: rtl/n64_poll_sequencer.sv
// Periodic N64 controller poll: sends the 0x01 command and a stop bit, arms the reader, then publishes the 32-bit word.
// Latency: TX takes 9*BIT_TICKS cycles, and polls start every POLL_PERIOD cycles. data_valid follows the LATCH cycle by one clock.
// No backpressure. Optional macro N64_DOUBLE_READ_EN publishes a word only after two equal consecutive reads.
module n64_poll_sequencer #(
  parameter int BIT_TICKS   = 400,
  parameter int POLL_PERIOD = 1666666,
  parameter int RSP_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        line_in,
  output logic        line_oe,
  output logic        rd_enable,
  input  logic        rd_working,
  input  logic        rd_error,
  input  logic [31:0] rd_data,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        fault,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_LATCH, S_FAULT, S_GAP} state_t;

  localparam logic [15:0] TICK_LAST    = 16'(BIT_TICKS - 1);
  localparam logic [15:0] ONE_LOW      = 16'(BIT_TICKS / 4);
  localparam logic [15:0] ZERO_LOW     = 16'((3 * BIT_TICKS) / 4);
  localparam logic [23:0] PERIOD_LAST  = 24'(POLL_PERIOD - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(RSP_TIMEOUT - 1);

  state_t      state, next_state;
  logic [15:0] tick_cnt;
  logic [3:0]  bit_cnt;
  logic [23:0] period_cnt;
  logic [23:0] tmo_cnt;
  logic        working_q;
  logic        line_meta, line_sync;

  logic slot_done, period_hit, timed_out, working_fall, tx_entry, contention;

  assign slot_done    = (tick_cnt == TICK_LAST);
  assign period_hit   = (period_cnt == PERIOD_LAST);
  assign timed_out    = (tmo_cnt == TIMEOUT_LAST);
  assign working_fall = working_q & ~rd_working;
  assign tx_entry     = (next_state == S_TX) && (state != S_TX);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a timeout beats a completion seen in the same cycle
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (enable) next_state = S_TX;
      S_TX:    if (slot_done && bit_cnt == 4'd8) next_state = S_WAIT;
      S_WAIT: begin
        if (timed_out)         next_state = S_FAULT;
        else if (working_fall) next_state = rd_error ? S_FAULT : S_LATCH;
      end
      // An overrun poll restarts immediately instead of passing through GAP
      S_LATCH, S_FAULT: next_state = (period_hit && enable) ? S_TX : S_GAP;
      S_GAP:   if (period_hit) next_state = enable ? S_TX : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state. In the command 0x01 sent MSB first, slots 0-6 are '0', slot 7 is '1', and slot 8 is the stop bit.
  always_comb begin
    line_oe   = 1'b0;
    rd_enable = 1'b0;
    busy      = 1'b1;
    case (state)
      S_TX:          line_oe = (bit_cnt >= 4'd7) ? (tick_cnt < ONE_LOW) : (tick_cnt < ZERO_LOW);
      S_WAIT:        rd_enable = 1'b1;
      S_IDLE, S_GAP: busy = 1'b0;
      default:       ;
    endcase
  end

  // Bit/period/timeout counters. They restart on state entry and saturate instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      period_cnt <= '0;
      tmo_cnt    <= '0;
      working_q  <= 1'b0;
    end else begin
      working_q <= rd_working;
      if (tx_entry) begin
        tick_cnt   <= '0;
        bit_cnt    <= '0;
        period_cnt <= '0;
      end else begin
        if (!period_hit) period_cnt <= period_cnt + 24'd1;
        if (state == S_TX) begin
          if (slot_done) begin
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
          end else begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end
      end
      if (state == S_WAIT) tmo_cnt <= tmo_cnt + 24'd1;
      else                 tmo_cnt <= '0;
    end
  end

`ifdef N64_DOUBLE_READ_EN
  logic [31:0] prev_word;
  logic        prev_vld;

  // Result registers. A word is published only when it matches the previous raw read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      fault      <= 1'b0;
      prev_word  <= '0;
      prev_vld   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state == S_LATCH) begin
        fault     <= 1'b0;
        prev_word <= rd_data;
        prev_vld  <= 1'b1;
        if (prev_vld && rd_data == prev_word) begin
          data_out   <= rd_data;
          data_valid <= 1'b1;
        end
      end else if (state == S_FAULT) begin
        fault    <= 1'b1;
        prev_vld <= 1'b0;
      end
    end
  end
`else
  // Result registers. Every successful read is published.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state == S_LATCH) begin
        fault      <= 1'b0;
        data_out   <= rd_data;
        data_valid <= 1'b1;
      end else if (state == S_FAULT) begin
        fault <= 1'b1;
      end
    end
  end
`endif

  // Two-flop line synchroniser. It idles high, matching the pull-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_meta <= 1'b1;
      line_sync <= 1'b1;
    end else begin
      line_meta <= line_in;
      line_sync <= line_meta;
    end
  end

  // Debug observation: another driver holding the line low while we are released between polls
  assign contention = (state == S_GAP) && !line_oe && !line_sync;
  cover property (@(posedge clk) disable iff (reset) contention);

endmodule

// File: tb/tb_n64_poll_sequencer.sv
// Bench for n64_poll_sequencer: directed poll sequence with randomized reader timing and data.
// Checks are made against a poll-level model of waveform, period, result and fault.
// Reader behaviour is modelled inline. Inputs are driven at the falling edge, and outputs are sampled there too.
module tb_n64_poll_sequencer;

  localparam int BT  = 8;
  localparam int PER = 200;
  localparam int TMO = 300;

`ifdef N64_DOUBLE_READ_EN
  localparam bit DOUBLE = 1'b1;
`else
  localparam bit DOUBLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, line_in, rd_working, rd_error;
  logic [31:0] rd_data;
  logic        line_oe, rd_enable, data_valid, fault, busy;
  logic [31:0] data_out;

  n64_poll_sequencer #(.BIT_TICKS(BT), .POLL_PERIOD(PER), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .line_in(line_in),
    .line_oe(line_oe), .rd_enable(rd_enable), .rd_working(rd_working),
    .rd_error(rd_error), .rd_data(rd_data), .data_out(data_out),
    .data_valid(data_valid), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int dv_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (data_valid === 1'b1) dv_cnt <= dv_cnt + 1;

  // Reference model state
  logic [31:0] exp_data = '0;
  logic        exp_fault = 1'b0;
  int          exp_dv = 0;
  logic [31:0] prev_word = '0;
  bit          prev_vld = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected line_oe for cycle i of the transmit frame: command 0x01 MSB first, then stop '1'
  function automatic logic exp_oe(input int i);
    logic [8:0] frame;
    int slot, t;
    logic b;
    frame = {8'h01, 1'b1};
    slot  = i / BT;
    t     = i % BT;
    b     = frame[8 - slot];
    return (t < (b ? BT / 4 : (3 * BT) / 4));
  endfunction

  // One full poll: waveform, reader response, result, and the predicted start of the next poll
  task automatic run_poll(input int exp_start, input bit never_done, input logic [31:0] word,
                          input logic err, input int drop_en_at, output int next_start);
    int n, s, k1, k2, rel;
    logic pub;
    n = 0;
    while (busy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_bound", 32'(n < 2000), 32'd1);
    s = cyc;
    check("tx_start_cycle", s, exp_start);
    for (int i = 0; i < 9 * BT; i++) begin
      check("line_oe_tx", line_oe, exp_oe(i));
      check("rd_enable_tx", rd_enable, 0);
      if (i == drop_en_at) enable = 1'b0;
      @(negedge clk);
    end
    check("rd_enable_wait", rd_enable, 1);
    check("line_oe_wait", line_oe, 0);
    check("dv_count", dv_cnt, exp_dv);
    if (never_done) begin
      rd_working = 1'b1;
      for (int k = 0; k < TMO; k++) begin
        if (k == TMO - 1) check("rd_enable_last_wait", rd_enable, 1);
        @(negedge clk);
      end
      check("rd_enable_fault", rd_enable, 0);
      check("busy_fault", busy, 1);
      rd_working = 1'b0;
      rel = 9 * BT + TMO;
      @(negedge clk);
      exp_fault = 1'b1;
      prev_vld  = 1'b0;
      pub       = 1'b0;
    end else begin
      k1 = $urandom_range(0, 20);
      k2 = k1 + $urandom_range(1, 50);
      for (int k = 0; k < k2; k++) begin
        if (k == k1) rd_working = 1'b1;
        @(negedge clk);
      end
      rd_working = 1'b0;
      rd_data    = word;
      rd_error   = err;
      @(negedge clk);
      check("rd_enable_done", rd_enable, 0);
      check("dv_before_latch", data_valid, 0);
      rel = 9 * BT + k2 + 1;
      @(negedge clk);
      if (err) begin
        exp_fault = 1'b1;
        prev_vld  = 1'b0;
        pub       = 1'b0;
      end else begin
        exp_fault = 1'b0;
        pub       = !DOUBLE || (prev_vld && word == prev_word);
        prev_word = word;
        prev_vld  = 1'b1;
        if (pub) begin
          exp_data = word;
          exp_dv++;
        end
      end
      rd_error = 1'b0;
    end
    check("data_valid", data_valid, pub);
    check("data_out", data_out, exp_data);
    check("fault", fault, exp_fault);
    next_start = s + ((rel + 1 > PER) ? rel + 1 : PER);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, busy_seen;
    reset = 1'b1; enable = 1'b0; line_in = 1'b1;
    rd_working = 1'b0; rd_error = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_line_oe", line_oe, 0);
    check("rst_rd_enable", rd_enable, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // First poll starts the cycle after enable rises
    enable = 1'b1;
    st = cyc + 1;
    run_poll(st, 1'b0, $urandom, 1'b0, -1, st);
    run_poll(st, 1'b0, $urandom, 1'b0, -1, st);
    // Missing controller: timeout fault, then a good read clears it
    run_poll(st, 1'b1, 32'h0, 1'b0, -1, st);
    run_poll(st, 1'b0, $urandom, 1'b0, -1, st);
    // Reader reports an error
    run_poll(st, 1'b0, $urandom, 1'b1, -1, st);
    // Repeated-word sequence
    run_poll(st, 1'b0, 32'h1234_0000, 1'b0, -1, st);
    run_poll(st, 1'b0, 32'h1234_0000, 1'b0, -1, st);
    run_poll(st, 1'b0, 32'h5678_0000, 1'b0, -1, st);
    // Random mix of good and bad reads
    for (int j = 0; j < 3; j++)
      run_poll(st, 1'b0, $urandom, 1'($urandom_range(0, 1)), -1, st);
    // Enable dropped mid-transmit: poll completes, then idle
    run_poll(st, 1'b0, $urandom, 1'b0, 20, st);
    busy_seen = 0;
    for (int k = 0; k < 300; k++) begin
      if (busy === 1'b1) busy_seen++;
      @(negedge clk);
    end
    check("idle_after_disable", busy_seen, 0);
    check("line_oe_idle", line_oe, 0);
    check("dv_count_final", dv_cnt, exp_dv);

    // Reset in the middle of a '0' slot releases the line at once
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("line_oe_mid_slot", line_oe, 1);
    reset = 1'b1;
    #1;
    check("arst_line_oe", line_oe, 0);
    check("arst_rd_enable", rd_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_data_out", data_out, 0);
    check("arst_data_valid", data_valid, 0);
    check("arst_fault", fault, 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
